// File: rtl/fwd_hazard_if.sv
// fwd_hazard_if: pipeline-side signal bundle for fwd_hazard_unit.
//   master : the pipeline (drives register addresses and stage control bits,
//            consumes forward selects, stall/bubble and multi-cycle WB info)
//   slave  : the hazard unit
// Signals:
//   id_rs/id_rt/id_uses_rs/id_uses_rt/id_is_mc  ID-stage sources and op kind
//   ex_rs/ex_rt/ex_rd/ex_memread/mc_start       EX-stage sources/dest/launch
//   mem_rd/mem_rt/mem_regwrite/mem_memwrite     MEM-stage dest/store reg
//   wb_rd/wb_regwrite                           WB-stage dest
//   fwd_a/fwd_b/fwd_s                           forwarding selects
//   stall/bubble                                freeze PC+IF/ID, NOP into ID/EX
//   mc_busy/mc_wb_valid/mc_wb_rd                multi-cycle op status
// Handshake: there is no valid/ready pair here. Every input is a level that
// is meaningful in the cycle it is presented; every combinational output
// (fwd_*, stall, bubble) answers for that same cycle, and mc_wb_valid is a
// single-cycle pulse that the pipeline must consume in the cycle it is high.
interface fwd_hazard_if #(
  parameter int AW = 5
);
  logic [AW-1:0] id_rs, id_rt;
  logic          id_uses_rs, id_uses_rt, id_is_mc;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd;
  logic          ex_memread, mc_start;
  logic [AW-1:0] mem_rd, mem_rt;
  logic          mem_regwrite, mem_memwrite;
  logic [AW-1:0] wb_rd;
  logic          wb_regwrite;
  logic [1:0]    fwd_a, fwd_b;
  logic          fwd_s, stall, bubble;
  logic          mc_busy, mc_wb_valid;
  logic [AW-1:0] mc_wb_rd;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mc,
           ex_rs, ex_rt, ex_rd, ex_memread, mc_start,
           mem_rd, mem_rt, mem_regwrite, mem_memwrite,
           wb_rd, wb_regwrite,
    input  fwd_a, fwd_b, fwd_s, stall, bubble,
           mc_busy, mc_wb_valid, mc_wb_rd
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mc,
           ex_rs, ex_rt, ex_rd, ex_memread, mc_start,
           mem_rd, mem_rt, mem_regwrite, mem_memwrite,
           wb_rd, wb_regwrite,
    output fwd_a, fwd_b, fwd_s, stall, bubble,
           mc_busy, mc_wb_valid, mc_wb_rd
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: forwarding selects, load-use / multi-cycle stall
// detection and a one-deep scoreboard for a multi-cycle ALU op.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   hz          fwd_hazard_if.slave (pipeline inputs, hazard outputs)
//   dbg_state   current multi-cycle FSM state (0 IDLE, 1 RUN, 2 WB)
//   stat_lu_cycles, stat_mc_cycles  saturating stall counters, present
//               only when FWD_HAZARD_STATS_EN is defined
// Parameters: AW register address width, MC_LAT multi-cycle latency
// (1..255), STAT_W statistic counter width.
// Register 0 is hard-wired zero and never forwarded or hazarded.
module fwd_hazard_unit #(
  parameter int AW     = 5,
  parameter int MC_LAT = 4,
  parameter int STAT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  fwd_hazard_if.slave hz,
  output logic [1:0]  dbg_state
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_lu_cycles,
  output logic [STAT_W-1:0] stat_mc_cycles
`endif
);

  localparam int CW = $clog2(MC_LAT) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WB = 2'd2} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] sb_rd;
  logic          wb_valid_q;

  logic          lu, mh, sh, pend;
  logic [AW-1:0] prd;

  // MEM is the younger producer, so it wins over WB.
  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src,
                                         input logic [AW-1:0] mrd,
                                         input logic          mwe,
                                         input logic [AW-1:0] wrd,
                                         input logic          wwe);
    if (mwe && mrd == src && mrd != '0)      fwd_sel = 2'b01;
    else if (wwe && wrd == src && wrd != '0) fwd_sel = 2'b10;
    else                                     fwd_sel = 2'b00;
  endfunction

  always_comb begin
    hz.fwd_a = fwd_sel(hz.ex_rs, hz.mem_rd, hz.mem_regwrite, hz.wb_rd, hz.wb_regwrite);
    hz.fwd_b = fwd_sel(hz.ex_rt, hz.mem_rd, hz.mem_regwrite, hz.wb_rd, hz.wb_regwrite);
    hz.fwd_s = hz.mem_memwrite && hz.wb_regwrite &&
               hz.wb_rd == hz.mem_rt && hz.wb_rd != '0;
  end

  // A launching op (mc_start in IDLE) already blocks its dependents in the
  // same cycle, before its destination has been captured into sb_rd.
  always_comb begin
    lu   = hz.ex_memread && hz.ex_rd != '0 &&
           ((hz.id_uses_rs && hz.id_rs == hz.ex_rd) ||
            (hz.id_uses_rt && hz.id_rt == hz.ex_rd));
    pend = (state != IDLE) || hz.mc_start;
    prd  = (state != IDLE) ? sb_rd : hz.ex_rd;
    mh   = pend && prd != '0 &&
           ((hz.id_uses_rs && hz.id_rs == prd) ||
            (hz.id_uses_rt && hz.id_rt == prd));
    sh   = hz.id_is_mc && pend;
  end

  assign hz.stall       = lu | mh | sh;
  assign hz.bubble      = lu | mh | sh;
  assign hz.mc_busy     = (state != IDLE);
  assign hz.mc_wb_valid = wb_valid_q;
  assign hz.mc_wb_rd    = sb_rd;
  assign dbg_state      = state;

  // RUN holds for MC_LAT cycles (cnt counts MC_LAT-1 down to 0), WB for one.
  // wb_valid_q is set on the RUN->WB edge so it is high exactly while in WB.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      sb_rd      <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (hz.mc_start) begin
            sb_rd <= hz.ex_rd;
            cnt   <= CW'(MC_LAT - 1);
            state <= RUN;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            state      <= WB;
            wb_valid_q <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_lu_cycles <= '0;
      stat_mc_cycles <= '0;
    end else begin
      if (lu && stat_lu_cycles != '1)
        stat_lu_cycles <= stat_lu_cycles + STAT_W'(1);
      if ((mh | sh) && stat_mc_cycles != '1)
        stat_mc_cycles <= stat_mc_cycles + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;
  localparam int AW     = 5;
  localparam int MC_LAT = 4;
  localparam int STAT_W = 8;
  localparam int W      = 13;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] dbg_state;
`ifdef FWD_HAZARD_STATS_EN
  logic [STAT_W-1:0] stat_lu_cycles, stat_mc_cycles;
`endif

  fwd_hazard_if #(.AW(AW)) hz ();

  fwd_hazard_unit #(.AW(AW), .MC_LAT(MC_LAT), .STAT_W(STAT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .hz        (hz),
    .dbg_state (dbg_state)
`ifdef FWD_HAZARD_STATS_EN
    ,
    .stat_lu_cycles (stat_lu_cycles),
    .stat_mc_cycles (stat_mc_cycles)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [AW-1:0] cur_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rs = 0; hz.id_uses_rt = 0; hz.id_is_mc = 0;
    hz.ex_rs = '0; hz.ex_rt = '0; hz.ex_rd = '0; hz.ex_memread = 0; hz.mc_start = 0;
    hz.mem_rd = '0; hz.mem_rt = '0; hz.mem_regwrite = 0; hz.mem_memwrite = 0;
    hz.wb_rd = '0; hz.wb_regwrite = 0;
  endtask

  // Push the expectation for the currently driven inputs, compare at the
  // falling edge, then move to just after the next rising edge.
  task automatic step(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                      input logic fs, input logic st, input logic busy,
                      input logic wbv, input logic [AW-1:0] wbrd);
    logic [W-1:0] e;
    exp_q.push_back({fa, fb, fs, st, busy, wbv, wbrd});
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, ".fwd_a"},  {30'd0, hz.fwd_a},      {30'd0, e[12:11]});
    check({tag, ".fwd_b"},  {30'd0, hz.fwd_b},      {30'd0, e[10:9]});
    check({tag, ".fwd_s"},  {31'd0, hz.fwd_s},      {31'd0, e[8]});
    check({tag, ".stall"},  {31'd0, hz.stall},      {31'd0, e[7]});
    check({tag, ".bubble"}, {31'd0, hz.bubble},     {31'd0, e[7]});
    check({tag, ".busy"},   {31'd0, hz.mc_busy},    {31'd0, e[6]});
    check({tag, ".wbv"},    {31'd0, hz.mc_wb_valid}, {31'd0, e[5]});
    check({tag, ".wbrd"},   {27'd0, hz.mc_wb_rd},   {27'd0, e[4:0]});
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] m_fwd(input logic [AW-1:0] src, input logic [AW-1:0] mrd,
                                       input logic mwe, input logic [AW-1:0] wrd, input logic wwe);
    if (mwe && mrd == src && mrd != 0) return 2'b01;
    if (wwe && wrd == src && wrd != 0) return 2'b10;
    return 2'b00;
  endfunction

  // Launch an MC op with destination rd, ID state set by caller beforehand.
  // st_dep: expected stall while the op is pending; st_after: after it.
  task automatic mc_run(input string tag, input logic [AW-1:0] rd,
                        input logic st_dep, input logic st_after);
    hz.mc_start = 1; hz.ex_rd = rd;
    step({tag, "_T"}, 2'b00, 2'b00, 0, st_dep, 0, 0, cur_rd);
    hz.mc_start = 0; hz.ex_rd = '0;
    cur_rd = rd;
    for (int i = 0; i < MC_LAT; i++) step({tag, "_run"}, 2'b00, 2'b00, 0, st_dep, 1, 0, rd);
    step({tag, "_wb"}, 2'b00, 2'b00, 0, st_dep, 1, 1, rd);
    step({tag, "_done"}, 2'b00, 2'b00, 0, st_after, 0, 0, rd);
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    cur_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    step("reset", 2'b00, 2'b00, 0, 0, 0, 0, '0);
    reset = 0;

    // forwarding priority
    hz.ex_rs = 3; hz.mem_rd = 3; hz.mem_regwrite = 1; hz.wb_rd = 3; hz.wb_regwrite = 1;
    step("fwd_mem", 2'b01, 2'b00, 0, 0, 0, 0, cur_rd);
    hz.mem_regwrite = 0;
    step("fwd_wb", 2'b10, 2'b00, 0, 0, 0, 0, cur_rd);
    hz.ex_rs = 0; hz.mem_rd = 0; hz.wb_rd = 0; hz.mem_regwrite = 1;
    step("fwd_r0", 2'b00, 2'b00, 0, 0, 0, 0, cur_rd);
    hz.ex_rs = 1; hz.ex_rt = 3; hz.mem_rd = 3; hz.wb_rd = 1;
    step("fwd_both", 2'b10, 2'b01, 0, 0, 0, 0, cur_rd);
    idle_inputs();

    // store-data forwarding
    hz.mem_memwrite = 1; hz.mem_rt = 7; hz.wb_rd = 7; hz.wb_regwrite = 1;
    step("fwd_s", 2'b00, 2'b00, 1, 0, 0, 0, cur_rd);
    hz.wb_rd = 0;
    step("fwd_s_r0", 2'b00, 2'b00, 0, 0, 0, 0, cur_rd);
    idle_inputs();

    // load-use: one stall cycle, then the bubble sits in EX
    hz.ex_memread = 1; hz.ex_rd = 5; hz.id_rs = 5; hz.id_uses_rs = 1;
    step("lu", 2'b00, 2'b00, 0, 1, 0, 0, cur_rd);
    hz.ex_memread = 0; hz.ex_rd = 0;
    step("lu_after", 2'b00, 2'b00, 0, 0, 0, 0, cur_rd);
    hz.ex_memread = 1; hz.ex_rd = 5; hz.id_uses_rs = 0; hz.id_rt = 5; hz.id_uses_rt = 0;
    step("lu_nouse", 2'b00, 2'b00, 0, 0, 0, 0, cur_rd);
    hz.id_uses_rt = 1;
    step("lu_rt", 2'b00, 2'b00, 0, 1, 0, 0, cur_rd);
    idle_inputs();

    // random forwarding / load-use against a reference model
    for (int i = 0; i < 40; i++) begin
      logic lu_e;
      hz.ex_rs = AW'($urandom_range(0, 7)); hz.ex_rt = AW'($urandom_range(0, 7));
      hz.ex_rd = AW'($urandom_range(0, 7)); hz.ex_memread = 1'($urandom_range(0, 1));
      hz.id_rs = AW'($urandom_range(0, 7)); hz.id_rt = AW'($urandom_range(0, 7));
      hz.id_uses_rs = 1'($urandom_range(0, 1)); hz.id_uses_rt = 1'($urandom_range(0, 1));
      hz.mem_rd = AW'($urandom_range(0, 7)); hz.mem_rt = AW'($urandom_range(0, 7));
      hz.mem_regwrite = 1'($urandom_range(0, 1)); hz.mem_memwrite = 1'($urandom_range(0, 1));
      hz.wb_rd = AW'($urandom_range(0, 7)); hz.wb_regwrite = 1'($urandom_range(0, 1));
      lu_e = hz.ex_memread && hz.ex_rd != 0 &&
             ((hz.id_uses_rs && hz.id_rs == hz.ex_rd) || (hz.id_uses_rt && hz.id_rt == hz.ex_rd));
      step("rand",
           m_fwd(hz.ex_rs, hz.mem_rd, hz.mem_regwrite, hz.wb_rd, hz.wb_regwrite),
           m_fwd(hz.ex_rt, hz.mem_rd, hz.mem_regwrite, hz.wb_rd, hz.wb_regwrite),
           hz.mem_memwrite && hz.wb_regwrite && hz.wb_rd == hz.mem_rt && hz.wb_rd != 0,
           lu_e, 0, 0, cur_rd);
    end
    idle_inputs();

    // dependent ID instruction waits for the multi-cycle result
    hz.id_rs = 9; hz.id_uses_rs = 1;
    mc_run("mc_dep", 9, 1, 0);
    idle_inputs();

    // structural: a second MC op in ID waits until the FSM is idle
    hz.id_is_mc = 1;
    mc_run("mc_struct", 4, 1, 0);
    idle_inputs();

    // non-dependent instruction flows through during RUN
    hz.id_rs = 2; hz.id_uses_rs = 1;
    mc_run("mc_indep", 9, 0, 0);
    idle_inputs();

    // reset in the middle of RUN discards the op
    hz.mc_start = 1; hz.ex_rd = 6;
    step("rst_T", 2'b00, 2'b00, 0, 0, 0, 0, cur_rd);
    hz.mc_start = 0; hz.ex_rd = 0;
    step("rst_T1", 2'b00, 2'b00, 0, 0, 1, 0, 6);
    reset = 1;
    step("rst_T2", 2'b00, 2'b00, 0, 0, 1, 0, 6);
    reset = 0;
    cur_rd = '0;
    for (int i = 0; i < MC_LAT + 2; i++) step("rst_after", 2'b00, 2'b00, 0, 0, 0, 0, '0);

`ifdef FWD_HAZARD_STATS_EN
    @(negedge clk);
    check("stat_lu_rst", {24'd0, stat_lu_cycles}, 32'd0);
    check("stat_mc_rst", {24'd0, stat_mc_cycles}, 32'd0);
    @(posedge clk); #1;
    hz.ex_memread = 1; hz.ex_rd = 5; hz.id_rs = 5; hz.id_uses_rs = 1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("stat_lu_sat", {24'd0, stat_lu_cycles}, 32'd255);
    check("stat_mc_idle", {24'd0, stat_mc_cycles}, 32'd0);
    idle_inputs();
`endif

    if (exp_q.size() != 0) check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
